// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the fifo_arbiter block: controller state encoding,
// default geometry and destination-field extraction for default-width words.
package fifo_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } arb_state_t;

  localparam int DEF_N_IN      = 4;
  localparam int DEF_N_OUT     = 4;
  localparam int DEF_WORD_SIZE = 6;
  localparam int DEF_DEST_L    = 2;
  localparam int DEF_ID_L      = 2;

  // Destination output FIFO lives in the top DEST_L bits of every word.
  function automatic logic [DEF_DEST_L-1:0] dest_of(input logic [DEF_WORD_SIZE-1:0] word);
    return word[DEF_WORD_SIZE-1 -: DEF_DEST_L];
  endfunction

endpackage

// File: rtl/fifo_arbiter_rr_pick.sv
// Combinational rotating priority encoder: returns the first set bit of
// mask found by scanning upward from start and wrapping past N-1 to 0.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] start,
  output logic           valid,
  output logic [IDW-1:0] winner
);

  int cand;

  // Scan the N candidates in rotated order and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    valid  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(start) + k) % N;
      if (!valid && mask[cand]) begin
        valid  = 1'b1;
        winner = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin scheduler moving head words from N_IN input FIFOs into the
// output FIFO named by each word's destination field, honouring per-output
// almost-full backpressure. Optional per-input grant counters are built when
// the ARB_STATS_EN macro is defined.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int N_IN      = DEF_N_IN,
  parameter int N_OUT     = DEF_N_OUT,
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int DEST_L    = DEF_DEST_L,
  parameter int ID_L      = DEF_ID_L
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic                      arb_en,
  input  logic [N_IN-1:0]           in_empty,
  input  logic [N_IN*WORD_SIZE-1:0] in_data,
  input  logic [N_OUT-1:0]          out_almost_full,
  output logic [N_IN-1:0]           pop,
  output logic [N_OUT-1:0]          push,
  output logic [WORD_SIZE-1:0]      data_out,
  output logic [ID_L-1:0]           grant_id,
  output logic                      busy
`ifdef ARB_STATS_EN
  ,
  output logic [N_IN*8-1:0]         grant_cnt
`endif
);

  arb_state_t           state, state_nxt;
  logic [ID_L-1:0]      last_grant;
  logic [ID_L-1:0]      start;
  logic [N_IN-1:0]      eligible;
  logic                 pick_valid;
  logic [ID_L-1:0]      pick_id;
  logic                 do_grant;
  logic [WORD_SIZE-1:0] win_word;
  logic [DEST_L-1:0]    win_dest;

  // An input may compete only if it holds a word and its target has room.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_IN; i++) begin
      eligible[i] = !in_empty[i] &&
                    !out_almost_full[in_data[i*WORD_SIZE + WORD_SIZE - DEST_L +: DEST_L]];
    end
  end

  assign start = (last_grant == ID_L'(N_IN - 1)) ? '0 : last_grant + 1'b1;

  rr_pick #(
    .N   (N_IN),
    .IDW (ID_L)
  ) u_pick (
    .mask   (eligible),
    .start  (start),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  // A grant happens only while running, enabled and out of reset; pop
  // must drop immediately on reset or on arb_en falling.
  assign do_grant = reset_L && (state == RUN) && arb_en && pick_valid;
  assign win_word = in_data[int'(pick_id)*WORD_SIZE +: WORD_SIZE];
  assign win_dest = win_word[WORD_SIZE-1 -: DEST_L];
  assign pop      = do_grant ? (N_IN'(1) << pick_id) : '0;
  assign busy     = (state == RUN) || (state == STOP);

  // Next-state logic for the IDLE/RUN/STOP controller.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_en) state_nxt = RUN;
      RUN:     if (!arb_en) state_nxt = STOP;
      STOP:    state_nxt = arb_en ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered push/data/grant outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset_L) begin
      state      <= IDLE;
      push       <= '0;
      data_out   <= '0;
      grant_id   <= '0;
      last_grant <= ID_L'(N_IN - 1);
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        push       <= N_OUT'(1) << win_dest;
        data_out   <= win_word;
        grant_id   <= pick_id;
        last_grant <= pick_id;
      end else begin
        push <= '0;
      end
    end
  end

`ifdef ARB_STATS_EN
  logic [7:0] cnt [N_IN];

  // Per-input grant counters, wrapping naturally at 8 bits.
  always_ff @(posedge clk) begin
    // NOTE: this is a small register array, not a RAM, so it is cleared by
    // reset like any other flop; a real memory array would not be.
    if (!reset_L) begin
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (pop[i]) cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  // Flatten the counter array onto the output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_IN; i++) grant_cnt[i*8 +: 8] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fifo_arbiter.sv
// Self-checking bench for fifo_arbiter: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a behavioural model.
module tb_fifo_arbiter;
  import fifo_arbiter_pkg::*;

  localparam int N_IN = 4;
  localparam int N_OUT = 4;
  localparam int WS = 6;
  localparam int IDL = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_L;
  logic                 arb_en;
  logic [N_IN-1:0]      in_empty;
  logic [N_IN*WS-1:0]   in_data;
  logic [N_OUT-1:0]     out_almost_full;
  logic [N_IN-1:0]      pop;
  logic [N_OUT-1:0]     push;
  logic [WS-1:0]        data_out;
  logic [IDL-1:0]       grant_id;
  logic                 busy;
`ifdef ARB_STATS_EN
  logic [N_IN*8-1:0]    grant_cnt;
`endif

  fifo_arbiter dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .arb_en          (arb_en),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .push            (push),
    .data_out        (data_out),
    .grant_id        (grant_id),
    .busy            (busy)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt       (grant_cnt)
`endif
  );

  int total = 0;
  int bad = 0;

  // Input FIFO contents as ring buffers; the FIFO is empty when wr == rd.
  logic [WS-1:0] mem [N_IN][DEPTH];
  int wr [N_IN];
  int rd [N_IN];

  // Reference model: mode 0=idle, 1=running, 2=stopping.
  int         m_mode;
  int         m_last;
  logic [3:0] m_push;
  logic [5:0] m_data;
  int         m_gid;
  int         m_cnt [N_IN];

  // Values observed in the most recent cycle, for directed checks.
  logic [3:0] s_pop, s_push;
  logic [5:0] s_data;
  logic [1:0] s_gid;
  logic       s_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic put(input int i, input logic [5:0] w);
    mem[i][wr[i] % DEPTH] = w;
    wr[i]++;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N_IN; i++) rd[i] = wr[i];
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_last = N_IN - 1;
    m_push = '0;
    m_data = '0;
    m_gid  = 0;
    for (int i = 0; i < N_IN; i++) m_cnt[i] = 0;
  endtask

  // One clock: present FIFO heads, check outputs at the falling edge,
  // advance the model and FIFOs, then return just after the next rising edge.
  task automatic cycle();
    int win;
    int c;
    logic [5:0] w;
    logic [3:0] epop;
    for (int i = 0; i < N_IN; i++) begin
      in_empty[i] = (wr[i] == rd[i]);
      in_data[i*WS +: WS] = in_empty[i] ? 6'($urandom) : mem[i][rd[i] % DEPTH];
    end
    #4;
    win = -1;
    if (reset_L && m_mode == 1 && arb_en) begin
      for (int k = 1; k <= N_IN; k++) begin
        c = (m_last + k) % N_IN;
        if (win < 0 && wr[c] != rd[c] && !out_almost_full[dest_of(mem[c][rd[c] % DEPTH])])
          win = c;
      end
    end
    epop = (win >= 0) ? 4'(1 << win) : 4'd0;
    s_pop = pop; s_push = push; s_data = data_out; s_gid = grant_id; s_busy = busy;
    check("pop", 32'(pop), 32'(epop));
    check("push", 32'(push), 32'(m_push));
    check("data_out", 32'(data_out), 32'(m_data));
    check("grant_id", 32'(grant_id), 32'(m_gid));
    check("busy", 32'(busy), 32'(m_mode != 0));
`ifdef ARB_STATS_EN
    for (int i = 0; i < N_IN; i++) check("grant_cnt", 32'(grant_cnt[i*8 +: 8]), 32'(m_cnt[i]));
`endif
    if (!reset_L) begin
      model_reset();
    end else begin
      if (win >= 0) begin
        w = mem[win][rd[win] % DEPTH];
        m_push = 4'(1 << dest_of(w));
        m_data = w;
        m_gid  = win;
        m_last = win;
        rd[win]++;
        m_cnt[win] = (m_cnt[win] + 1) % 256;
      end else begin
        m_push = '0;
      end
      case (m_mode)
        0: if (arb_en) m_mode = 1;
        1: if (!arb_en) m_mode = 2;
        default: m_mode = arb_en ? 1 : 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  int prev;

  initial begin
    for (int i = 0; i < N_IN; i++) begin wr[i] = 0; rd[i] = 0; end
    reset_L = 1'b0;
    arb_en = 1'b0;
    out_almost_full = '0;
    in_empty = '1;
    in_data = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset held with every input non-empty and arb_en high.
    for (int i = 0; i < N_IN; i++) put(i, 6'h3F);
    arb_en = 1'b1;
    for (int n = 0; n < 3; n++) begin
      cycle();
      check("rst_pop", 32'(s_pop), 32'd0);
      check("rst_busy", 32'(s_busy), 32'd0);
    end
    clear_queues();

    // Single word from input 0: pop in t, push/data in t+1.
    reset_L = 1'b1;
    cycle();
    put(0, 6'b10_1010);
    cycle();
    check("tp_pop0", 32'(s_pop), 32'b0001);
    cycle();
    check("tp_push", 32'(s_push), 32'b0100);
    check("tp_data", 32'(s_data), 32'h2A);

    // All inputs busy toward output 0: grants rotate, push[0] every cycle.
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < 2; j++) put(i, 6'(i * 4 + j));
    cycle();
    prev = int'(s_gid);
    for (int n = 0; n < 5; n++) begin
      cycle();
      check("rr_seq", 32'(s_gid), 32'((prev + 1) % N_IN));
      check("rr_push0", 32'(s_push), 32'b0001);
      prev = int'(s_gid);
    end
    clear_queues();
    cycle();

    // Backpressure on output 3 blocks input 1; input 2 keeps flowing.
    out_almost_full = 4'b1000;
    put(1, 6'b11_0001);
    for (int j = 0; j < 6; j++) put(2, 6'(j));
    for (int n = 0; n < 3; n++) begin
      cycle();
      check("blk_pop1", 32'(s_pop[1]), 32'd0);
    end
    out_almost_full = '0;
    cycle();
    check("rr_after", 32'(s_pop), 32'b0010);
    clear_queues();
    cycle();

    // Dropping arb_en during traffic.
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < 4; j++) put(i, 6'(j));
    cycle();
    cycle();
    arb_en = 1'b0;
    cycle();
    check("stop_pop", 32'(s_pop), 32'd0);
    check("stop_push", 32'(s_push), 32'b0001);
    check("stop_busy0", 32'(s_busy), 32'd1);
    cycle();
    check("stop_busy1", 32'(s_busy), 32'd1);
    check("stop_push1", 32'(s_push), 32'd0);
    cycle();
    check("stop_busy2", 32'(s_busy), 32'd0);

    // Reset in the middle of a stream.
    arb_en = 1'b1;
    cycle();
    cycle();
    reset_L = 1'b0;
    cycle();
    check("midrst_pop", 32'(s_pop), 32'd0);
    reset_L = 1'b1;
    cycle();
    check("midrst_push", 32'(s_push), 32'd0);
    check("midrst_data", 32'(s_data), 32'd0);
    check("midrst_gid", 32'(s_gid), 32'd0);
    check("midrst_busy", 32'(s_busy), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset_L = ($urandom_range(0, 99) != 0);
      arb_en = ($urandom_range(0, 7) != 0);
      out_almost_full = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < N_IN; i++)
        if ((wr[i] - rd[i]) < 8 && $urandom_range(0, 1) == 1) put(i, 6'($urandom));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
